// File: rtl/prod_accum.sv
// Sums a group of unsigned 16-bit products (LEN beats or up to in_last); result valid the cycle after the last beat.
// Input stalls while a result is held; PROD_ACCUM_SAT_EN selects saturating instead of wrapping overflow.
module prod_accum #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      prod_in,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       acc_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0]       LEN_C   = 8'(LEN);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             ovf_q, ovf_nxt;

  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_inc;
  logic             beat;
  logic             grp_end;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

  // acc is zero in IDLE, so the first beat uses the same adder path as later beats.
  assign sum     = {1'b0, acc} + (ACC_W+1)'(prod_in);
  assign cnt_inc = cnt + 8'd1;
  assign grp_end = (cnt_inc == LEN_C) || in_last;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_q;
    case (state)
      IDLE, ACC: begin
        if (beat) begin
          cnt_nxt = cnt_inc;
          ovf_nxt = ovf_q | sum[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
          // Once clamped, the sum stays at full scale for the rest of the group.
          acc_nxt = (ovf_q || sum[ACC_W]) ? ACC_MAX : sum[ACC_W-1:0];
`else
          acc_nxt = sum[ACC_W-1:0];
`endif
          state_nxt = grp_end ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign acc_out = acc;
  assign acc_cnt = cnt;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Randomized and directed checks of prod_accum against a group-sum reference model, on three parameterizations.
module tb_prod_accum;

  logic        clk;
  logic        rst;
  logic        iv  [3];
  logic        il  [3];
  logic        orr [3];
  logic [15:0] pi  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic        of  [3];
  logic [7:0]  ac  [3];
  logic [23:0] ao0, ao2;
  logic [16:0] ao1;
  logic [31:0] aov [3];

  int w_of   [3] = '{24, 17, 24};
  int len_of [3] = '{8, 3, 1};

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] bq[$];
  bit          lq[$];

  assign aov[0] = 32'(ao0);
  assign aov[1] = 32'(ao1);
  assign aov[2] = 32'(ao2);

  prod_accum #(.ACC_W(24), .LEN(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .prod_in(pi[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(orr[0]), .acc_out(ao0),
    .acc_cnt(ac[0]), .ovf(of[0]));

  prod_accum #(.ACC_W(17), .LEN(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .prod_in(pi[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(orr[1]), .acc_out(ao1),
    .acc_cnt(ac[1]), .ovf(of[1]));

  prod_accum #(.ACC_W(24), .LEN(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .prod_in(pi[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(orr[2]), .acc_out(ao2),
    .acc_cnt(ac[2]), .ovf(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Group result from the arithmetic rules: sum beats until in_last or LEN,
  // then fold the true total into ACC_W bits.
  function automatic void model(input int w, input int len, output int cnt,
                                output longint unsigned acc, output bit ovr);
    longint unsigned tot;
    longint unsigned mx;
    tot = 0;
    cnt = 0;
    mx  = (64'd1 << w) - 1;
    for (int i = 0; i < bq.size(); i++) begin
      tot += 64'(bq[i]);
      cnt++;
      if (cnt == len || lq[i]) break;
    end
    ovr = (tot > mx);
`ifdef PROD_ACCUM_SAT_EN
    acc = ovr ? mx : tot;
`else
    acc = tot & mx;
`endif
  endfunction

  task automatic gen(input int d, input int last_pct, input int lo);
    bq.delete();
    lq.delete();
    for (int i = 0; i < len_of[d]; i++) begin
      bq.push_back(16'($urandom_range(lo, 65535)));
      lq.push_back($urandom_range(0, 99) < last_pct);
    end
  endtask

  task automatic check_outs(input int d, input string tag, input logic [31:0] eacc,
                            input logic [31:0] ecnt, input logic [31:0] eov);
    check({tag, "_out_valid"}, 32'(ov[d]), 32'd1);
    check({tag, "_acc_out"},   aov[d], eacc);
    check({tag, "_acc_cnt"},   32'(ac[d]), ecnt);
    check({tag, "_ovf"},       32'(of[d]), eov);
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_out_valid"}, 32'(ov[d]), 32'd0);
    check({tag, "_acc_out"},   aov[d], 32'd0);
    check({tag, "_acc_cnt"},   32'(ac[d]), 32'd0);
    check({tag, "_ovf"},       32'(of[d]), 32'd0);
    check({tag, "_in_ready"},  32'(ir[d]), 32'd1);
  endtask

  // Drive the group held in bq/lq into DUT d, with up to max_gap idle cycles
  // before each beat and out_ready held low for `hold` cycles once done.
  task automatic run_group(input int d, input int max_gap, input int hold);
    int              cnt;
    longint unsigned eacc;
    bit              eov;
    model(w_of[d], len_of[d], cnt, eacc, eov);
    orr[d] = (hold == 0);
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        iv[d] = 1'b0;
        @(posedge clk); #1;
        check("gap_out_valid", 32'(ov[d]), 32'd0);
      end
      iv[d] = 1'b1;
      pi[d] = bq[i];
      il[d] = lq[i];
      check("beat_in_ready", 32'(ir[d]), 32'd1);
      @(posedge clk); #1;
      if (i < cnt - 1) check("mid_out_valid", 32'(ov[d]), 32'd0);
    end
    iv[d] = 1'b0;
    il[d] = 1'b0;
    check_outs(d, "done", 32'(eacc), 32'(cnt), 32'(eov));
    check("done_in_ready", 32'(ir[d]), 32'd0);
    repeat (hold) begin
      iv[d] = 1'b1;
      pi[d] = 16'($urandom);
      il[d] = 1'b1;
      @(posedge clk); #1;
      check_outs(d, "hold", 32'(eacc), 32'(cnt), 32'(eov));
    end
    iv[d]  = 1'b0;
    il[d]  = 1'b0;
    orr[d] = 1'b1;
    @(posedge clk); #1;
    check("xfer_out_valid", 32'(ov[d]), 32'd0);
    check("xfer_in_ready", 32'(ir[d]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; il[d] = 1'b0; orr[d] = 1'b1; pi[d] = '0;
    end

    // Reset state, then in_ready from the first cycle after release.
    #2;
    for (int d = 0; d < 3; d++) check_zero(d, "reset");
    #10 rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) check_zero(d, "post_reset");

    // Eight full-scale beats back to back.
    bq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    lq = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_group(0, 0, 0);

    // Early termination on the third beat.
    bq = '{16'd1, 16'd2, 16'd3};
    lq = '{0, 0, 1};
    run_group(0, 0, 0);

    // in_last on the LEN-th beat.
    bq = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    lq = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_group(0, 1, 0);

    // Result held for five cycles with ignored input pulses.
    bq = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    lq = '{0, 0, 0, 1};
    run_group(0, 0, 5);

    // Overflow on the narrow accumulator.
    bq = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    lq = '{0, 0, 0};
    run_group(1, 0, 0);

    // Single-beat groups.
    bq = '{16'h1234};
    lq = '{0};
    run_group(2, 0, 0);
    bq = '{16'h0010};
    lq = '{0};
    run_group(2, 0, 0);

    // Reset after four of eight beats discards the partial group.
    orr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; pi[0] = 16'h0777; il[0] = 1'b0;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero(0, "rst_mid");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_zero(0, "rst_mid_after");
    bq = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    lq = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_group(0, 0, 0);

    // Reset while a result is held.
    orr[0] = 1'b0;
    iv[0] = 1'b1; pi[0] = 16'h00AB; il[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; il[0] = 1'b0;
    check_outs(0, "held", 32'h00AB, 32'd1, 32'd0);
    #2 rst = 1'b1;
    #1 check_zero(0, "rst_done");
    #2 rst = 1'b0;
    orr[0] = 1'b1;
    @(posedge clk); #1;
    check_zero(0, "rst_done_after");

    // Randomized groups on each configuration.
    for (int g = 0; g < 25; g++) begin
      gen(0, 15, 0);
      run_group(0, 2, $urandom_range(0, 3));
    end
    for (int g = 0; g < 15; g++) begin
      gen(1, 20, ($urandom_range(0, 1) == 1) ? 40000 : 0);
      run_group(1, 1, $urandom_range(0, 2));
    end
    for (int g = 0; g < 6; g++) begin
      gen(2, 50, 0);
      run_group(2, 1, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter ACC_W, default 24: accumulator width in bits, legal range 17..32.
REQ-002 Parameter LEN, default 8: products per group, legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: prod_in and in_last are valid.
REQ-006 Port in_ready, output, 1: block can accept a product this cycle.
REQ-007 Port prod_in, input, 16: unsigned 16-bit product from the 8x8 inexact multiplier.
REQ-008 Port in_last, input, 1: marks this beat as the final beat of the group (early termination).
REQ-009 Port out_valid, output, 1: group result is presented.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port acc_out, output, ACC_W: accumulated group sum.
REQ-012 Port acc_cnt, output, 8: number of products summed into acc_out.
REQ-013 Port ovf, output, 1: an overflow occurred in this group (wrap or saturate event).

Function
REQ-014 An input beat is accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-015 A result transfer occurs on a clock edge where out_valid=1 and out_ready=1.
REQ-016 FSM states: IDLE, ACC, DONE; state is registered.
REQ-017 IDLE: in_ready=1, out_valid=0, acc=0, cnt=0, ovf=0.
REQ-018 IDLE, beat accepted: acc<=zero-extended prod_in, cnt<=1; go to DONE if LEN==1 or in_last=1, else go to ACC.
REQ-019 ACC: in_ready=1, out_valid=0; on a beat, acc<=acc+prod_in, cnt<=cnt+1; go to DONE when the new cnt equals LEN or in_last=1, else stay in ACC.
REQ-020 ACC with no beat accepted: all state holds; there is no timeout.
REQ-021 DONE: in_ready=0, out_valid=1; acc_out, acc_cnt and ovf stay stable until the result transfer.
REQ-022 DONE, result transfer: go to IDLE with acc, cnt and ovf cleared; the next beat can be accepted on the following cycle.
REQ-023 Latency: out_valid rises on the cycle after the final beat is accepted.
REQ-024 Throughput: one idle cycle between groups (DONE to IDLE).
REQ-025 acc_out, acc_cnt and ovf are driven from registers at all times; their values are meaningful only while out_valid=1.
REQ-026 An addition whose carry exceeds ACC_W bits is an overflow event; ovf sets and stays set (sticky) until the group is cleared.
REQ-027 in_last asserted on the beat where cnt reaches LEN has the same effect as reaching LEN alone.
REQ-028 in_valid, prod_in and in_last are ignored while in_ready=0.

Reset
REQ-029 rst=1 forces, asynchronously: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, acc_out=0, acc_cnt=0.
REQ-030 Reset asserted mid-group or in DONE discards the partial or held result; no output transfer occurs.
REQ-031 After rst deasserts, in_ready=1 from the first clock cycle.

Configuration
REQ-032 Macro PROD_ACCUM_SAT_EN selects the overflow behaviour.
REQ-033 With PROD_ACCUM_SAT_EN defined: on overflow, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the group; ovf=1.
REQ-034 With PROD_ACCUM_SAT_EN undefined: acc wraps modulo 2^ACC_W; ovf=1.

Verification
REQ-035 ACC_W=24, LEN=8; 8 beats of 0xFFFF back-to-back, out_ready=1 -> acc_out=0x07FFF8, acc_cnt=8, ovf=0, out_valid for one cycle, one cycle after beat 8.
REQ-036 Beats 1, 2, 3 with in_last on beat 3 -> acc_out=6, acc_cnt=3; in_ready=0 while out_valid=1.
REQ-037 ACC_W=17, LEN=3, 3 beats of 0xFFFF -> without the macro acc_out=0x0FFFD, ovf=1; with PROD_ACCUM_SAT_EN acc_out=0x1FFFF, ovf=1.
REQ-038 Group completes, out_ready held low 5 cycles -> out_valid, acc_out and acc_cnt stable for 5 cycles; in_valid pulses during that time are ignored; transfer occurs on the 6th cycle.
REQ-039 rst pulsed after 4 of 8 beats -> all outputs 0 immediately; a new group of 8 beats of 0x0001 gives acc_out=8, acc_cnt=8.
REQ-040 LEN=1; beats 0x1234 and 0x0010 with out_ready=1 -> two results, 0x001234 then 0x000010, each with acc_cnt=1.
